// File: rtl/apb5_rr_pkg.sv
// apb5_rr_pkg: shared state, command bundle and index helper.
// Build option: APB5_RR_TIMEOUT_EN enables the ACCESS-phase timeout.
package apb5_rr_pkg;

  localparam int CMD_AW = 32;
  localparam int CMD_DW = 32;
  localparam int CMD_SW = CMD_DW / 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  typedef struct packed {
    logic [CMD_AW-1:0] addr;
    logic [2:0]        prot;
    logic              nse;
    logic              write;
    logic [CMD_DW-1:0] wdata;
    logic [CMD_SW-1:0] strb;
  } cmd_t;

  function automatic int wrap_idx(input int v, input int n);
    return v % n;
  endfunction

endpackage

// File: rtl/apb5_rr_pick.sv
// apb5_rr_pick: combinational round-robin picker.
// Search starts one past the last grant and wraps to zero.
module apb5_rr_pick
  import apb5_rr_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] idx,
  output logic                       any
);

  localparam int IW = $clog2(NUM_REQ);

  logic [IW-1:0] j;

  // first requester found after the last grant wins
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = IW'(wrap_idx(int'(last) + k, NUM_REQ));
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = j;
      end
    end
  end

endmodule

// File: rtl/apb5_rr_requester.sv
// apb5_rr_requester: round-robin arbiter driving one APB5 requester port.
// Build option: APB5_RR_TIMEOUT_EN ends stalled ACCESS phases with an error.
module apb5_rr_requester
  import apb5_rr_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                               pclk,
  input  logic                               preset,
  input  logic [NUM_REQ-1:0]                 req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]      req_addr,
  input  logic [NUM_REQ-1:0]                 req_write,
  input  logic [NUM_REQ-1:0]                 req_nse,
  input  logic [NUM_REQ*3-1:0]               req_prot,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]      req_wdata,
  input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0]  req_strb,
  output logic [NUM_REQ-1:0]                 req_ack,
  output logic [NUM_REQ-1:0]                 rsp_valid,
  output logic [DATA_WIDTH-1:0]              rsp_rdata,
  output logic                               rsp_err,
  output logic [ADDR_WIDTH-1:0]              paddr,
  output logic [2:0]                         pprot,
  output logic                               pnse,
  output logic                               pselx,
  output logic                               penable,
  output logic                               pwrite,
  output logic [DATA_WIDTH-1:0]              pwdata,
  output logic [DATA_WIDTH/8-1:0]            pstrb,
  output logic                               pwakeup,
  input  logic                               pready,
  input  logic [DATA_WIDTH-1:0]              prdata,
  input  logic                               pslverr
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int SW = DATA_WIDTH / 8;

  localparam logic [1:0] IDLE   = ST_IDLE;
  localparam logic [1:0] SETUP  = ST_SETUP;
  localparam logic [1:0] ACCESS = ST_ACCESS;

  logic [1:0]         state;
  cmd_t               cmd_q;
  cmd_t               cmd_n;
  logic [IW-1:0]      owner;
  logic [IW-1:0]      last;
  logic [IW-1:0]      win_idx;
  logic [NUM_REQ-1:0] win_oh;
  logic               win_any;
  logic               tmo;
  logic               done;
  logic               arb;

  apb5_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req   (req_valid),
    .last  (last),
    .grant (win_oh),
    .idx   (win_idx),
    .any   (win_any)
  );

  // select the winning requester's command; reads never strobe
  always_comb begin
    cmd_n = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_oh[i]) begin
        cmd_n.addr  = CMD_AW'(req_addr[i*ADDR_WIDTH +: ADDR_WIDTH]);
        cmd_n.prot  = req_prot[i*3 +: 3];
        cmd_n.nse   = req_nse[i];
        cmd_n.write = req_write[i];
        cmd_n.wdata = CMD_DW'(req_wdata[i*DATA_WIDTH +: DATA_WIDTH]);
        cmd_n.strb  = req_write[i] ? CMD_SW'(req_strb[i*SW +: SW]) : '0;
      end
    end
  end

`ifdef APB5_RR_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] wait_cnt;

  assign tmo = (state == ACCESS) && !pready &&
               (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

  // count consecutive ACCESS cycles stalled on pready
  always_ff @(posedge pclk) begin
    if (preset || state != ACCESS || pready || tmo) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  logic unused_tmo_cfg;

  assign tmo            = 1'b0;
  assign unused_tmo_cfg = ^TIMEOUT_CYCLES;
`endif

  assign done = (state == ACCESS) && (pready || tmo);
  assign arb  = win_any && ((state == IDLE) || done);

  assign pselx   = (state != IDLE);
  assign penable = (state == ACCESS);
  assign paddr   = cmd_q.addr[ADDR_WIDTH-1:0];
  assign pprot   = cmd_q.prot;
  assign pnse    = cmd_q.nse;
  assign pwrite  = cmd_q.write;
  assign pwdata  = cmd_q.wdata[DATA_WIDTH-1:0];
  assign pstrb   = cmd_q.strb[SW-1:0];

  // transfer sequencing, grant bookkeeping and response pulses
  always_ff @(posedge pclk) begin
    if (preset) begin
      state     <= IDLE;
      cmd_q     <= '0;
      owner     <= '0;
      last      <= IW'(NUM_REQ - 1);
      req_ack   <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      pwakeup   <= 1'b0;
    end else begin
      req_ack   <= '0;
      rsp_valid <= '0;
      pwakeup   <= (|req_valid) || (state != IDLE);
      if (done) begin
        rsp_valid <= NUM_REQ'(1) << owner;
        rsp_rdata <= (pready && !cmd_q.write) ? prdata : '0;
        rsp_err   <= pready ? pslverr : 1'b1;
      end
      if (arb) begin
        state   <= SETUP;
        cmd_q   <= cmd_n;
        owner   <= win_idx;
        last    <= win_idx;
        req_ack <= win_oh;
      end else if (state == SETUP) begin
        state <= ACCESS;
      end else if (done) begin
        state <= IDLE;
      end
    end
  end

endmodule
